// File: rtl/arb_mon_pkg.sv
// Shared constants and helpers for the arbiter protocol monitor.
package arb_mon_pkg;

  localparam int unsigned ERR_ONEHOT = 0;
  localparam int unsigned ERR_UNREQ  = 1;
  localparam int unsigned ERR_ID     = 2;
  localparam int unsigned ERR_PRE    = 3;
  localparam int unsigned ERR_ORDER  = 4;
  localparam int unsigned ERR_STARVE = 5;
  localparam int unsigned ERR_W      = 6;

  localparam int unsigned MODE_PRIORITY = 0;
  localparam int unsigned MODE_RR       = 1;

  // Ceiling log2; constant-evaluable so it can size ports and counters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_mon_starve.sv
// Per-requester wait counters; flags requesters that reach STARVE_MAX cycles ungranted.
module arb_mon_starve
  import arb_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] grt,
  output logic [WIDTH-1:0] starving,
  output logic [WIDTH-1:0] rise_c
);

  localparam int unsigned   CW      = clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] starving_d;

  // Counters restart whenever the requester drops or is served.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!req[i] || grt[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      starving_d[i] = (cnt_d[i] == CNT_MAX);
    end
  end

  assign rise_c = starving_d & ~starving;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      starving <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      starving <= starving_d;
    end
  end

endmodule

// File: rtl/arb_protocol_monitor.sv
// Passive checker for priority / round-robin arbiters with look-ahead grant buses.
module arb_protocol_monitor
  import arb_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BITW       = clog2(WIDTH),
  parameter int unsigned MODE       = MODE_PRIORITY,
  parameter int unsigned STARVE_MAX = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] grt,
  input  logic [BITW:0]    id,
  input  logic [WIDTH-1:0] pre_grt,
  input  logic [BITW:0]    pre_id,
  input  logic             clr,
  output logic [ERR_W-1:0] err_pulse,
  output logic [ERR_W-1:0] err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] starving
);

  localparam int unsigned IDW = BITW + 1;

  logic [WIDTH-1:0] req_d;
  logic [WIDTH-1:0] grt_d;
  logic [WIDTH-1:0] pre_grt_d;
  logic [IDW-1:0]   pre_id_d;
  logic             rst_n_d;
  logic [BITW-1:0]  last_idx;

  logic             multi_c;
  logic             onehot_c;
  logic             new_grant_c;
  logic [BITW-1:0]  grt_idx_c;
  logic [BITW-1:0]  exp_idx_c;
  logic [ERR_W-1:0] err_c;
  logic [WIDTH-1:0] starve_rise_c;

  function automatic logic [BITW-1:0] lowest_idx(input logic [WIDTH-1:0] vec);
    logic [BITW-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = BITW'(i);
    end
    return idx;
  endfunction

  // First set bit at or after last+1, wrapping; scanned far-to-near so the nearest wins.
  function automatic logic [BITW-1:0] cyclic_first(input logic [WIDTH-1:0] vec,
                                                   input logic [BITW-1:0]  last);
    logic [BITW-1:0] idx;
    int unsigned     pos;
    idx = last;
    for (int k = WIDTH; k >= 1; k--) begin
      pos = 32'(last) + 32'(k);
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (vec[pos]) idx = BITW'(pos);
    end
    return idx;
  endfunction

  always_comb begin
    multi_c     = |(grt & (grt - WIDTH'(1)));
    onehot_c    = (grt != '0) && !multi_c;
    grt_idx_c   = lowest_idx(grt);
    new_grant_c = onehot_c && (grt != grt_d) && (req_d != '0);
    exp_idx_c   = (MODE == MODE_RR) ? cyclic_first(req_d, last_idx) : lowest_idx(req_d);
  end

  always_comb begin
    err_c             = '0;
    err_c[ERR_ONEHOT] = multi_c;
    err_c[ERR_UNREQ]  = |(grt & ~req & ~req_d);
    err_c[ERR_ID]     = onehot_c && (id != IDW'(grt_idx_c));
    err_c[ERR_PRE]    = rst_n_d && ((grt !== pre_grt_d) || (id !== pre_id_d));
    err_c[ERR_ORDER]  = new_grant_c && (grt_idx_c != exp_idx_c);
    err_c[ERR_STARVE] = |starve_rise_c;
  end

  if (STARVE_MAX > 0) begin : g_starve
    arb_mon_starve #(
      .WIDTH      (WIDTH),
      .STARVE_MAX (STARVE_MAX)
    ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .grt      (grt),
      .starving (starving),
      .rise_c   (starve_rise_c)
    );
  end else begin : g_no_starve
    assign starving      = '0;
    assign starve_rise_c = '0;
  end

  // One-cycle history of the monitored buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d     <= '0;
      grt_d     <= '0;
      pre_grt_d <= '0;
      pre_id_d  <= '0;
      rst_n_d   <= 1'b0;
      last_idx  <= '0;
    end else begin
      req_d     <= req;
      grt_d     <= grt;
      pre_grt_d <= pre_grt;
      pre_id_d  <= pre_id;
      rst_n_d   <= 1'b1;
      if (new_grant_c) last_idx <= grt_idx_c;
    end
  end

  // A clear never hides an error raised on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_c;
      if (clr) begin
        err_sticky <= err_c;
        err_cnt    <= {{(CNT_W - 1){1'b0}}, |err_c};
      end else begin
        err_sticky <= err_sticky | err_c;
        if ((err_c != '0) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arb_protocol_monitor.sv
// Directed bench: a priority and a round-robin monitor watch the same stimulus.
module tb_arb_protocol_monitor;

  localparam int unsigned W   = 4;
  localparam int unsigned IDW = 3;

  logic           clk;
  logic           rst_n;
  logic           clr;
  logic [W-1:0]   req;
  logic [W-1:0]   grt;
  logic [IDW-1:0] id;
  logic [W-1:0]   pre_grt;
  logic [IDW-1:0] pre_id;

  logic [5:0]   p_pulse, p_sticky, r_pulse, r_sticky;
  logic [3:0]   p_cnt, r_cnt;
  logic [W-1:0] p_starving, r_starving;

  int n_checks;
  int n_errors;

  arb_protocol_monitor #(
    .WIDTH(4), .MODE(0), .STARVE_MAX(4), .CNT_W(4)
  ) u_dut_prio (
    .clk(clk), .rst_n(rst_n), .req(req), .grt(grt), .id(id),
    .pre_grt(pre_grt), .pre_id(pre_id), .clr(clr),
    .err_pulse(p_pulse), .err_sticky(p_sticky), .err_cnt(p_cnt), .starving(p_starving)
  );

  arb_protocol_monitor #(
    .WIDTH(4), .MODE(1), .STARVE_MAX(4), .CNT_W(4)
  ) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .grt(grt), .id(id),
    .pre_grt(pre_grt), .pre_id(pre_id), .clr(clr),
    .err_pulse(r_pulse), .err_sticky(r_sticky), .err_cnt(r_cnt), .starving(r_starving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: req/grt/id now, plus the look-ahead for the next cycle.
  task automatic cyc(input logic [W-1:0] r, input logic [W-1:0] g, input logic [IDW-1:0] i,
                     input logic [W-1:0] ng, input logic [IDW-1:0] ni);
    req     = r;
    grt     = g;
    id      = i;
    pre_grt = ng;
    pre_id  = ni;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    req      = '0;
    grt      = '0;
    id       = '0;
    pre_grt  = '0;
    pre_id   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pulse",   32'(p_pulse),    32'h0);
    check("rst_sticky",  32'(p_sticky),   32'h0);
    check("rst_cnt",     32'(r_cnt),      32'h0);
    check("rst_starve",  32'(r_starving), 32'h0);
    rst_n = 1'b1;

    // Legal priority grant after two request cycles.
    cyc(4'b1010, 4'b0000, 3'd0, 4'b0000, 3'd0);
    cyc(4'b1010, 4'b0000, 3'd0, 4'b0010, 3'd1);
    cyc(4'b1010, 4'b0010, 3'd1, 4'b0010, 3'd1);
    check("legal_p",     32'(p_pulse), 32'h0);
    check("legal_r",     32'(r_pulse), 32'h0);
    check("legal_cnt",   32'(p_cnt),   32'h0);

    // Priority violation: req_d=0110 granted to 2.
    cyc(4'b0110, 4'b0010, 3'd1, 4'b0100, 3'd2);
    cyc(4'b0110, 4'b0100, 3'd2, 4'b0100, 3'd2);
    check("order_p",     32'(p_pulse), 32'h10);
    check("order_rr_ok", 32'(r_pulse), 32'h0);
    cyc(4'b0110, 4'b0100, 3'd2, 4'b0000, 3'd0);
    check("order_stk",   32'(p_sticky), 32'h10);
    check("order_cnt",   32'(p_cnt),    32'h1);
    check("order_pclr",  32'(p_pulse),  32'h0);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);

    // Round-robin: last_idx=2, req_d=1011 -> must pick 3, not 0.
    cyc(4'b1011, 4'b0000, 3'd0, 4'b0001, 3'd0);
    cyc(4'b1011, 4'b0001, 3'd0, 4'b0001, 3'd0);
    check("rr_bad",      32'(r_pulse), 32'h10);
    check("rr_bad_p",    32'(p_pulse), 32'h0);
    cyc(4'b0100, 4'b0001, 3'd0, 4'b0100, 3'd2);
    check("drop_tol",    32'(r_pulse), 32'h0);
    cyc(4'b1011, 4'b0100, 3'd2, 4'b1000, 3'd3);
    check("rr_to2",      32'(r_pulse), 32'h0);
    cyc(4'b1011, 4'b1000, 3'd3, 4'b1000, 3'd3);
    check("rr_good",     32'(r_pulse), 32'h0);
    check("rr_good_p",   32'(p_pulse), 32'h10);
    cyc(4'b0000, 4'b1000, 3'd3, 4'b0000, 3'd0);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    check("cnt_p2",      32'(p_cnt), 32'h2);
    check("cnt_r1",      32'(r_cnt), 32'h1);

    // Multi-hot unrequested grant: several bits, one count.
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0110, 3'd1);
    cyc(4'b0000, 4'b0110, 3'd1, 4'b0000, 3'd0);
    check("multi_p",     32'(p_pulse & 6'b111011), 32'h03);
    check("multi_r",     32'(r_pulse & 6'b111011), 32'h03);
    check("multi_cntp",  32'(p_cnt), 32'h3);
    check("multi_cntr",  32'(r_cnt), 32'h2);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);

    // Wrong id on a one-hot grant.
    cyc(4'b0010, 4'b0000, 3'd0, 4'b0010, 3'd3);
    cyc(4'b0010, 4'b0010, 3'd3, 4'b0000, 3'd0);
    check("id_p",        32'(p_pulse), 32'h04);
    check("id_r",        32'(r_pulse), 32'h04);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);

    // Look-ahead promised a grant that never came.
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0001, 3'd0);
    cyc(4'b0001, 4'b0000, 3'd0, 4'b0000, 3'd0);
    check("pre_p",       32'(p_pulse), 32'h08);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);

    // Starvation of requester 3.
    cyc(4'b1000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    cyc(4'b1000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    cyc(4'b1000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    check("starve_pre",  32'(p_starving), 32'h0);
    cyc(4'b1000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    check("starve_vec",  32'(p_starving), 32'h8);
    check("starve_pul",  32'(r_pulse),    32'h20);
    cyc(4'b1000, 4'b0000, 3'd0, 4'b1000, 3'd3);
    check("starve_hold", 32'(r_starving), 32'h8);
    check("starve_once", 32'(p_pulse),    32'h0);
    cyc(4'b1000, 4'b1000, 3'd3, 4'b0000, 3'd0);
    check("starve_clr",  32'(p_starving), 32'h0);
    check("served_ok",   32'(r_pulse),    32'h0);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    check("sticky_p",    32'(p_sticky), 32'h3F);
    check("sticky_r",    32'(r_sticky), 32'h3F);
    check("cnt_p6",      32'(p_cnt),    32'h6);
    check("cnt_r5",      32'(r_cnt),    32'h5);

    // Sixteen consecutive look-ahead mismatches saturate the counter.
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0001, 3'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(4'b0000, 4'b0000, 3'd0, (k == 15) ? 4'b0000 : 4'b0001, 3'd0);
    end
    check("sat_p",       32'(p_cnt),   32'hF);
    check("sat_r",       32'(r_cnt),   32'hF);
    check("sat_pulse",   32'(p_pulse), 32'h08);

    // Clear on a clean edge, then clear racing a new error.
    clr = 1'b1;
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0001, 3'd0);
    check("clr_stk",     32'(p_sticky), 32'h0);
    check("clr_cnt",     32'(r_cnt),    32'h0);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    clr = 1'b0;
    check("clr_win_stk", 32'(r_sticky), 32'h08);
    check("clr_win_cnt", 32'(p_cnt),    32'h1);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0010, 3'd1);

    // Asynchronous reset mid-run; PRE is ignored on the first edge after release.
    rst_n = 1'b0;
    #1;
    check("arst_stk",    32'(p_sticky), 32'h0);
    check("arst_cnt",    32'(r_cnt),    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b0100, 4'b0100, 3'd2, 4'b0000, 3'd0);
    check("rel_nopre_p", 32'(p_pulse), 32'h0);
    check("rel_nopre_r", 32'(r_pulse), 32'h0);
    cyc(4'b0100, 4'b0100, 3'd2, 4'b0000, 3'd0);
    check("rel_pre_on",  32'(p_pulse), 32'h08);
    cyc(4'b0000, 4'b0000, 3'd0, 4'b0000, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
